// File: rtl/cmdin_copy_opt.sv
// cmdin_copy_opt
//   Streaming stage in front of the accelerator cmdin interconnect. Parses
//   each command and remembers the last value seen per (accelerator, argument
//   index). When an argument repeats and the accelerator already holds that
//   data, the in-copy flag bit of its flag word is cleared. Every other word,
//   along with tdest and tlast, passes through unchanged.
//
//   Optional feature macro: CMDIN_COPY_OPT_STATS_EN
//     defined     -> opt_count is a 32-bit saturating count of cleared flags
//     not defined -> opt_count is tied to 0 and no counter is built
//
// Ports
//   clk, rst                      clock, async active-high reset
//   in_data/in_dest/in_last       command word, destination, last marker
//   in_valid/in_ready             upstream handshake
//   out_data/out_dest/out_last    forwarded word
//   out_valid/out_ready           downstream handshake
//   inval_valid/inval_acc         pulse: forget every argument of inval_acc
//   opt_count                     number of cleared in-copy flags
module cmdin_copy_opt #(
  parameter int NUM_ACCS = 16,
  parameter int MAX_ARGS = 15,
  parameter int ACC_BITS = $clog2(NUM_ACCS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [63:0]         in_data,
  input  logic [ACC_BITS-1:0] in_dest,
  input  logic                in_last,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [63:0]         out_data,
  output logic [ACC_BITS-1:0] out_dest,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                inval_valid,
  input  logic [ACC_BITS-1:0] inval_acc,
  output logic [31:0]         opt_count
);

  // OmpSsManager command word layout
  localparam int CMD_TYPE_L      = 0;
  localparam int CMD_TYPE_H      = 7;
  localparam int NUM_ARGS_OFFSET = 8;
  localparam int ARG_FLAG_L      = 0;
  localparam logic [7:0] SETUP_HW_INST_CODE  = 8'd2;
  localparam logic [7:0] EXEC_PERI_TASK_CODE = 8'd5;

  localparam int IN_BIT = ARG_FLAG_L + 4;  // in-copy flag
  localparam int IDX_W  = (MAX_ARGS > 1) ? $clog2(MAX_ARGS) : 1;
  localparam logic [8:0]        MAX_ARGS_B = MAX_ARGS[8:0];
  localparam logic [ACC_BITS:0] NUM_ACCS_B = NUM_ACCS[ACC_BITS:0];

  typedef enum logic [2:0] {HEADER, TID, PTID, PERIOD, ARGFLAG, ARG} state_t;

  state_t                state;
  logic [7:0]            code;
  logic [7:0]            nargs;
  logic [7:0]            arg_idx;

  // flag word held back until its argument arrives
  logic [63:0]           flag_buf;
  logic [ACC_BITS-1:0]   flag_dest;
  logic                  flag_last;

  // argument word parked while its flag occupies the output register
  logic [63:0]           pend_data;
  logic [ACC_BITS-1:0]   pend_dest;
  logic                  pend_last;
  logic                  pend_vld;

  // argument history
  logic [63:0]                          tbl_val [NUM_ACCS][MAX_ARGS];
  logic [NUM_ACCS-1:0][MAX_ARGS-1:0]    tbl_vld;

  logic              out_free, accept;
  logic              idx_ok, dest_ok, inval_ok, tbl_wr, hit;
  logic [IDX_W-1:0]  tidx;
  logic [63:0]       flag_out;
  logic [7:0]        idx_nxt;

  assign out_free = !out_valid || out_ready;
  // no new word while the arg of a flag/arg pair is still parked
  assign in_ready = !rst && !pend_vld && out_free;
  assign accept   = in_valid && in_ready;

  assign idx_ok   = {1'b0, arg_idx} < MAX_ARGS_B;
  assign dest_ok  = {1'b0, in_dest} < NUM_ACCS_B;
  assign inval_ok = {1'b0, inval_acc} < NUM_ACCS_B;
  assign tidx     = arg_idx[IDX_W-1:0];
  assign idx_nxt  = arg_idx + 8'd1;

  // Lookup sees the table as it was before this arg is written.
  assign hit = (state == ARG) && idx_ok && dest_ok && flag_buf[IN_BIT] &&
               tbl_vld[in_dest][tidx] && (tbl_val[in_dest][tidx] == in_data);
  assign tbl_wr = accept && (state == ARG) && idx_ok && dest_ok;

  always_comb begin
    flag_out = flag_buf;
    if (hit) flag_out[IN_BIT] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (tbl_wr) tbl_val[in_dest][tidx] <= in_data;
  end

  // Invalidate first so a same-cycle update keeps its own entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_vld <= '0;
    end else begin
      if (inval_valid && inval_ok) tbl_vld[inval_acc] <= '0;
      if (tbl_wr) tbl_vld[in_dest][tidx] <= flag_buf[IN_BIT];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HEADER;
      code      <= '0;
      nargs     <= '0;
      arg_idx   <= '0;
      flag_buf  <= '0;
      flag_dest <= '0;
      flag_last <= 1'b0;
      pend_data <= '0;
      pend_dest <= '0;
      pend_last <= 1'b0;
      pend_vld  <= 1'b0;
      out_data  <= '0;
      out_dest  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;

      // second half of a flag/arg pair
      if (pend_vld && out_free) begin
        out_data  <= pend_data;
        out_dest  <= pend_dest;
        out_last  <= pend_last;
        out_valid <= 1'b1;
        pend_vld  <= 1'b0;
      end

      if (accept) begin
        if (state inside {HEADER, TID, PTID, PERIOD}) begin
          out_data  <= in_data;
          out_dest  <= in_dest;
          out_last  <= in_last;
          out_valid <= 1'b1;
        end
        unique case (state)
          HEADER: begin
            code    <= in_data[CMD_TYPE_H:CMD_TYPE_L];
            nargs   <= in_data[NUM_ARGS_OFFSET +: 8];
            arg_idx <= '0;
            state   <= TID;
          end
          TID:    state <= (code == SETUP_HW_INST_CODE) ? HEADER : PTID;
          PTID: begin
            if (code == EXEC_PERI_TASK_CODE) state <= PERIOD;
            else if (nargs != 8'd0)          state <= ARGFLAG;
            else                             state <= HEADER;
          end
          PERIOD: state <= (nargs != 8'd0) ? ARGFLAG : HEADER;
          ARGFLAG: begin
            flag_buf  <= in_data;
            flag_dest <= in_dest;
            flag_last <= in_last;
            state     <= ARG;
          end
          ARG: begin
            out_data  <= flag_out;
            out_dest  <= flag_dest;
            out_last  <= flag_last;
            out_valid <= 1'b1;
            pend_data <= in_data;
            pend_dest <= in_dest;
            pend_last <= in_last;
            pend_vld  <= 1'b1;
            arg_idx   <= idx_nxt;
            state     <= (idx_nxt == nargs) ? HEADER : ARGFLAG;
          end
          default: state <= HEADER;
        endcase
      end
    end
  end

`ifdef CMDIN_COPY_OPT_STATS_EN
  logic [31:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      cnt <= '0;
    else if (accept && hit && cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;
  end
  assign opt_count = cnt;
`else
  assign opt_count = 32'd0;
`endif

endmodule

// File: tb/tb_cmdin_copy_opt.sv
// Bench for cmdin_copy_opt: constant vector table, hand sequences for the
// multi-cycle corners, then randomized commands against a command-level model.
module tb_cmdin_copy_opt;
  localparam int NA = 16;
  localparam int MA = 15;
  localparam int AB = 4;
  localparam logic [7:0] EXEC  = 8'd1;
  localparam logic [7:0] SETUP = 8'd2;
  localparam logic [7:0] PERI  = 8'd5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   in_data = '0;
  logic [AB-1:0] in_dest = '0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   out_data;
  logic [AB-1:0] out_dest;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          inval_valid = 1'b0;
  logic [AB-1:0] inval_acc = '0;
  logic [31:0]   opt_count;

  cmdin_copy_opt #(.NUM_ACCS(NA), .MAX_ARGS(MA), .ACC_BITS(AB)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_dest(out_dest), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .inval_valid(inval_valid), .inval_acc(inval_acc),
    .opt_count(opt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]   d;
    logic [AB-1:0] dst;
    logic          l;
  } word_t;

  typedef struct {
    logic [AB-1:0] dst;
    logic [63:0]   arg;
    logic [63:0]   flag;
    logic [63:0]   exp_flag;
    int            cnt;
  } vec_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    rdy_pct = 100;
  word_t exp_q[$];

  // command-level reference state
  logic [63:0] m_val [NA][MA];
  logic        m_vld [NA][MA];
  int          m_cnt;

  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Downstream: random ready, in-order word check, stability under stall.
  initial begin : monitor
    logic        hold_chk;
    logic [68:0] held;
    word_t       e;
    hold_chk = 1'b0;
    held     = '0;
    forever begin
      @(negedge clk);
      out_ready = ($urandom_range(99) < rdy_pct);
      if (rst) begin
        hold_chk = 1'b0;
      end else begin
        if (hold_chk)
          chk("hold", {out_valid, out_data, out_dest, out_last}, {1'b1, held});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", {out_data, out_dest, out_last}, '0);
            if (!(out_data == '0 && out_dest == '0 && out_last == 1'b0)) ; else begin
              n_fail++;
              $display("FAIL unexpected_word: got %0h want none", out_data);
            end
          end else begin
            e = exp_q.pop_front();
            chk("out_word", {out_data, out_dest, out_last}, {e.d, e.dst, e.l});
          end
        end
        hold_chk = out_valid && !out_ready;
        held     = {out_data, out_dest, out_last};
      end
    end
  end

  initial begin : watchdog
    #900000;
    n_tests++; n_fail++;
    $display("FAIL watchdog: got timeout want completion");
    finish_tb();
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [63:0] d, input logic [AB-1:0] dst, input logic l);
    int n;
    n = 0;
    in_data = d; in_dest = dst; in_last = l; in_valid = 1'b1;
    while (1) begin
      #4;
      if (in_ready) break;
      @(negedge clk);
      n++;
      if (n > 2000) begin
        n_tests++; n_fail++;
        $display("FAIL in_ready_timeout: got stuck want accept");
        finish_tb();
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [63:0] d, input logic [AB-1:0] dst, input logic l);
    word_t w;
    w.d = d; w.dst = dst; w.l = l;
    exp_q.push_back(w);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 5000) break;
    end
    repeat (3) @(negedge clk);
    chk(name, 128'(exp_q.size()), 128'd0);
    exp_q.delete();
  endtask

  task automatic model_reset();
    for (int a = 0; a < NA; a++)
      for (int i = 0; i < MA; i++) m_vld[a][i] = 1'b0;
    m_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);
    chk("post_rst_out_valid", 128'(out_valid), 128'd0);
    chk("post_rst_opt_count", 128'(opt_count), 128'd0);
    @(negedge clk);
    exp_q.delete();
    model_reset();
  endtask

  function automatic logic [63:0] hdr(input logic [7:0] code, input logic [7:0] n);
    return {48'h0, n, code};
  endfunction

  // single-argument EXEC command with a hand-derived expected flag
  task automatic exec1(input logic [AB-1:0] d, input logic [63:0] a, input logic [63:0] f,
                       input logic [63:0] e, input int tag);
    push_exp(hdr(EXEC, 8'd1), d, 1'b0);
    push_exp(64'h7100_0000 + 64'(tag), d, 1'b0);
    push_exp(64'h7200_0000 + 64'(tag), d, 1'b0);
    push_exp(e, d, 1'b0);
    push_exp(a, d, 1'b1);
    send(hdr(EXEC, 8'd1), d, 1'b0);
    send(64'h7100_0000 + 64'(tag), d, 1'b0);
    send(64'h7200_0000 + 64'(tag), d, 1'b0);
    send(f, d, 1'b0);
    send(a, d, 1'b1);
  endtask

  // two-argument EXEC command; optional invalidate pulse aligned to arg0
  task automatic cmd2(input logic [AB-1:0] d, input logic [63:0] a0, input logic [63:0] a1,
                      input logic [63:0] e0, input logic [63:0] e1, input logic inv0);
    push_exp(hdr(EXEC, 8'd2), d, 1'b0);
    push_exp(64'h8100, d, 1'b0);
    push_exp(64'h8200, d, 1'b0);
    push_exp(e0, d, 1'b0);
    push_exp(a0, d, 1'b0);
    push_exp(e1, d, 1'b0);
    push_exp(a1, d, 1'b1);
    send(hdr(EXEC, 8'd2), d, 1'b0);
    send(64'h8100, d, 1'b0);
    send(64'h8200, d, 1'b0);
    send(64'h10, d, 1'b0);
    inval_valid = inv0; inval_acc = d;
    send(a0, d, 1'b0);
    inval_valid = 1'b0;
    send(64'h10, d, 1'b0);
    send(a1, d, 1'b1);
  endtask

  task automatic check_count(input string name, input int want);
`ifdef CMDIN_COPY_OPT_STATS_EN
    chk(name, 128'(opt_count), 128'(want));
`else
    chk(name, 128'(opt_count), 128'(want * 0));
`endif
  endtask

  // Random command; expected output derived from the argument rules.
  task automatic rand_cmd();
    word_t       li[$];
    word_t       le[$];
    word_t       w;
    logic [7:0]  code;
    logic [AB-1:0] dst;
    int          na, r;
    logic [63:0] f, a, ef;
    r    = $urandom_range(9);
    code = (r < 6) ? EXEC : (r < 8) ? PERI : (r == 8) ? SETUP : 8'h07;
    dst  = AB'($urandom_range(2));
    na   = ($urandom_range(9) == 0) ? $urandom_range(17, 15) : $urandom_range(3);
    w.dst = dst; w.l = 1'b0;
    w.d = {32'($urandom), 16'($urandom), 8'(na), code}; li.push_back(w); le.push_back(w);
    w.d = {$urandom, $urandom};                          li.push_back(w); le.push_back(w);
    if (code != SETUP) begin
      w.d = {$urandom, $urandom}; li.push_back(w); le.push_back(w);
      if (code == PERI) begin
        w.d = {$urandom, $urandom}; li.push_back(w); le.push_back(w);
      end
      for (int i = 0; i < na; i++) begin
        f  = {$urandom, $urandom};
        a  = 64'($urandom_range(2));
        ef = f;
        if (i < MA) begin
          if (m_vld[dst][i] && m_val[dst][i] == a && f[4]) begin
            ef[4] = 1'b0;
            m_cnt++;
          end
          m_val[dst][i] = a;
          m_vld[dst][i] = f[4];
        end
        w.d = f;  li.push_back(w);
        w.d = ef; le.push_back(w);
        w.d = a;  li.push_back(w); le.push_back(w);
      end
    end
    li[li.size()-1].l = 1'b1;
    le[le.size()-1].l = 1'b1;
    foreach (le[k]) exp_q.push_back(le[k]);
    foreach (li[k]) send(li[k].d, li[k].dst, li[k].l);
    if ($urandom_range(99) < 15) begin
      inval_acc = AB'($urandom_range(2));
      inval_valid = 1'b1;
      for (int i = 0; i < MA; i++) m_vld[inval_acc][i] = 1'b0;
      @(negedge clk);
      inval_valid = 1'b0;
    end
  endtask

  initial begin : main
    vec_t tv [10];
    tv[0] = '{4'd3, 64'h1000, 64'h10, 64'h10, 0};
    tv[1] = '{4'd3, 64'h1000, 64'h10, 64'h00, 1};
    tv[2] = '{4'd3, 64'h2000, 64'h10, 64'h10, 1};
    tv[3] = '{4'd3, 64'h2000, 64'h10, 64'h00, 2};
    tv[4] = '{4'd4, 64'h2000, 64'h10, 64'h10, 2};
    tv[5] = '{4'd3, 64'h2000, 64'h30, 64'h20, 3};
    tv[6] = '{4'd3, 64'h2000, 64'h00, 64'h00, 3};
    tv[7] = '{4'd3, 64'h2000, 64'h10, 64'h10, 3};
    tv[8] = '{4'd3, 64'h2000, 64'h10, 64'h00, 4};
    tv[9] = '{4'd3, 64'h2000, 64'hDEAD_0000_0000_00DF, 64'hDEAD_0000_0000_00CF, 5};

    #1;
    chk("rst0_in_ready", 128'(in_ready), 128'd0);
    chk("rst0_out_valid", 128'(out_valid), 128'd0);
    do_reset();

    // constant vectors
    rdy_pct = 100;
    foreach (tv[i]) begin
      exec1(tv[i].dst, tv[i].arg, tv[i].flag, tv[i].exp_flag, i);
      wait_drain("vec_drain");
      check_count("vec_opt_count", tv[i].cnt);
    end

    // invalidate between commands
    exec1(4'd10, 64'hA0, 64'h10, 64'h10, 20);
    @(negedge clk);
    inval_valid = 1'b1; inval_acc = 4'd10;
    @(negedge clk);
    inval_valid = 1'b0;
    exec1(4'd10, 64'hA0, 64'h10, 64'h10, 21);
    exec1(4'd10, 64'hA0, 64'h10, 64'h00, 22);
    wait_drain("inval_drain");

    // invalidate in the same cycle as the arg0 update: arg0 survives
    cmd2(4'd11, 64'hB0, 64'hB1, 64'h10, 64'h10, 1'b0);
    cmd2(4'd11, 64'hB0, 64'hB1, 64'h00, 64'h10, 1'b1);
    cmd2(4'd11, 64'hB0, 64'hB1, 64'h00, 64'h00, 1'b0);
    wait_drain("inval_coincide_drain");

    // periodic task + setup under heavy backpressure
    rdy_pct = 30;
    for (int rep = 0; rep < 2; rep++) begin
      push_exp(hdr(PERI, 8'd2), 4'd7, 1'b0);
      push_exp(64'h7000_0001, 4'd7, 1'b0);
      push_exp(64'h7000_0002, 4'd7, rep == 1);
      push_exp(64'hFEED_0000_0000_0010, 4'd7, 1'b0);
      push_exp((rep == 0) ? 64'h10 : 64'h00, 4'd7, 1'b0);
      push_exp(64'h70, 4'd7, 1'b0);
      push_exp((rep == 0) ? 64'h30 : 64'h20, 4'd7, 1'b0);
      push_exp(64'h71, 4'd7, 1'b1);
      push_exp(hdr(SETUP, 8'd3), 4'd9, 1'b0);
      push_exp(64'h10, 4'd9, 1'b1);
      send(hdr(PERI, 8'd2), 4'd7, 1'b0);
      send(64'h7000_0001, 4'd7, 1'b0);
      send(64'h7000_0002, 4'd7, rep == 1);
      send(64'hFEED_0000_0000_0010, 4'd7, 1'b0);
      send(64'h10, 4'd7, 1'b0);
      send(64'h70, 4'd7, 1'b0);
      send(64'h30, 4'd7, 1'b0);
      send(64'h71, 4'd7, 1'b1);
      send(hdr(SETUP, 8'd3), 4'd9, 1'b0);
      send(64'h10, 4'd9, 1'b1);
    end
    wait_drain("peri_setup_drain");

    // reset between a flag word and its arg word
    rdy_pct = 100;
    exec1(4'd5, 64'h5555, 64'h10, 64'h10, 30);
    push_exp(hdr(EXEC, 8'd1), 4'd5, 1'b0);
    push_exp(64'h31, 4'd5, 1'b0);
    push_exp(64'h32, 4'd5, 1'b0);
    send(hdr(EXEC, 8'd1), 4'd5, 1'b0);
    send(64'h31, 4'd5, 1'b0);
    send(64'h32, 4'd5, 1'b0);
    send(64'h10, 4'd5, 1'b0);
    wait_drain("pre_rst_drain");
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_out_after_rst", 128'(out_valid), 128'd0);
    end
    exec1(4'd5, 64'h5555, 64'h10, 64'h10, 33);
    wait_drain("post_rst_cmd_drain");

    // randomized commands against the model
    do_reset();
    rdy_pct = 70;
    for (int k = 0; k < 60; k++) rand_cmd();
    wait_drain("rand_drain");
    check_count("rand_opt_count", m_cnt);

    finish_tb();
  end
endmodule
